// File: rtl/t08_keypad_scanner_if.sv
// rtl/t08_keypad_scanner_if.sv - key event valid/ready handshake bundle
interface t08_keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_overflow;

  modport master (
    output key_code,
    output key_valid,
    input  key_ready,
    output key_overflow
  );

  modport slave (
    input  key_code,
    input  key_valid,
    output key_ready,
    input  key_overflow
  );
endinterface

// File: rtl/t08_keypad_scanner.sv
// rtl/t08_keypad_scanner.sv - 4x4 active-low key matrix scanner with debounce and key event register
module t08_keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        en,
  input  logic [3:0]                  rows_in,
  output logic [3:0]                  cols_out,
  output logic [3:0]                  cols_oeb,
  t08_keypad_scanner_if.master        key_if
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] STABLE_MAX  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q;
  logic [3:0]       row_s1_q, row_s2_q;
  logic [15:0]      frame_q, prev_frame_q, deb_q, deb_old_q;
  logic [CNT_W-1:0] stable_q;
  logic             frame_done_q, deb_upd_q;
  logic [3:0]       code_q;
  logic             valid_q, ovf_q;

  logic             sample_w, event_w, xfer_w;
  logic [3:0]       ev_code_w, col_sel_w;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = SCAN;
      SCAN:    if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only the active column is driven; the rest float so two keys in one row cannot short.
  always_comb begin
    col_sel_w = 4'b0001 << col_q;
    cols_out  = 4'hF;
    cols_oeb  = 4'hF;
    if (state_q == SCAN) begin
      cols_out = ~col_sel_w;
      cols_oeb = ~col_sel_w;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      row_s1_q <= '0;
      row_s2_q <= '0;
    end else begin
      row_s1_q <= rows_in;
      row_s2_q <= row_s1_q;
    end
  end

  assign sample_w = (state_q == SCAN) && (div_q == DIV_LAST);
  assign xfer_w   = valid_q && key_if.key_ready;

  // Frame bit index is col*4+row; the key code swaps that to row*4+col.
  always_comb begin
    ev_code_w = '0;
    for (int i = 0; i < 16; i++) begin
      if (deb_q[i]) ev_code_w = {i[1:0], i[3:2]};
    end
    event_w = deb_upd_q && (deb_q != 16'h0) && ((deb_q & (deb_q - 16'd1)) == 16'h0)
              && ((deb_q & deb_old_q) == 16'h0);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_q        <= '0;
      col_q        <= '0;
      frame_q      <= '0;
      prev_frame_q <= '0;
      stable_q     <= '0;
      deb_q        <= '0;
      deb_old_q    <= '0;
      frame_done_q <= 1'b0;
      deb_upd_q    <= 1'b0;
      code_q       <= '0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (!en) begin
      div_q        <= '0;
      col_q        <= '0;
      frame_q      <= '0;
      prev_frame_q <= '0;
      stable_q     <= '0;
      deb_q        <= '0;
      deb_old_q    <= '0;
      frame_done_q <= 1'b0;
      deb_upd_q    <= 1'b0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      deb_upd_q    <= 1'b0;
      ovf_q        <= 1'b0;

      if (state_q == SCAN) begin
        if (sample_w) begin
          frame_q[{col_q, 2'b00} +: 4] <= ~row_s2_q;
          div_q        <= '0;
          col_q        <= col_q + 2'd1;
          frame_done_q <= (col_q == 2'd3);
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end

      if (frame_done_q) begin
        if (frame_q != prev_frame_q) begin
          prev_frame_q <= frame_q;
          stable_q     <= '0;
        end else if (stable_q != STABLE_MAX) begin
          stable_q <= stable_q + CNT_W'(1);
          if (stable_q == STABLE_LAST) begin
            deb_old_q <= deb_q;
            deb_q     <= frame_q;
            deb_upd_q <= 1'b1;
          end
        end
      end

      // A transfer in the same cycle frees the slot, so the new event is taken rather than dropped.
      if (event_w) begin
        if (!valid_q || xfer_w) begin
          code_q  <= ev_code_w;
          valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (xfer_w) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign key_if.key_code     = code_q;
  assign key_if.key_valid    = valid_q;
  assign key_if.key_overflow = ovf_q;
endmodule

// File: tb/tb_t08_keypad_scanner.sv
// tb/tb_t08_keypad_scanner.sv - directed and randomized bench for the keypad scanner
module tb_t08_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  rows_in;
  logic [3:0]  cols_out, cols_oeb;
  logic [15:0] keys = 16'h0;

  int checks = 0;
  int errors = 0;
  int bad, lat, n, ovf_cnt, r_ovf;
  logic [3:0]  e;
  logic [15:0] m, deb;
  logic [15:0] frames[$];
  logic [3:0]  got[$];
  logic [3:0]  expq[$];

  t08_keypad_scanner_if kif();

  t08_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .en      (en),
    .rows_in (rows_in),
    .cols_out(cols_out),
    .cols_oeb(cols_oeb),
    .key_if  (kif)
  );

  always #5 clk = ~clk;

  // Key bit index = row*4+col; a pressed key pulls its row low only while its column is driven low.
  always_comb begin
    rows_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols_oeb[c] && !cols_out[c]) rows_in[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cnt);
    repeat (cnt) @(negedge clk);
  endtask

  task automatic wait_frame_start();
    int k;
    k = 0;
    while (cols_oeb !== 4'h7 && k < 100) begin @(negedge clk); k++; end
    while (cols_oeb !== 4'hE && k < 100) begin @(negedge clk); k++; end
    check("frame_align", 32'(k < 100), 1);
  endtask

  task automatic wait_valid(input int bound, output int l);
    l = 0;
    while (kif.key_valid !== 1'b1 && l < bound) begin @(negedge clk); l++; end
  endtask

  task automatic accept();
    kif.key_ready = 1'b1;
    tick(1);
    kif.key_ready = 1'b0;
  endtask

  task automatic step();
    kif.key_ready = ($urandom % 2 == 0);
    if (kif.key_valid === 1'b1 && kif.key_ready) got.push_back(kif.key_code);
    @(negedge clk);
    if (kif.key_overflow === 1'b1) r_ovf++;
  endtask

  initial begin
    kif.key_ready = 1'b0;
    tick(3);
    check("rst_cols_out", cols_out, 4'hF);
    check("rst_cols_oeb", cols_oeb, 4'hF);
    check("rst_valid", kif.key_valid, 0);
    check("rst_code", kif.key_code, 0);
    check("rst_ovf", kif.key_overflow, 0);

    nrst = 1'b1;
    bad = 0;
    repeat (50) begin
      tick(1);
      if (cols_oeb !== 4'hF || cols_out !== 4'hF || kif.key_valid !== 1'b0) bad++;
    end
    check("idle_hold", bad, 0);

    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      e = ~(4'b0001 << (k / 4));
      check("col_seq_oeb", cols_oeb, e);
      check("col_seq_out", cols_out, e);
    end

    // single press of key 6
    wait_frame_start();
    keys = 16'h0040;
    wait_valid(100, lat);
    check("press_latency_ok", 32'(lat >= 48 && lat <= 68), 1);
    check("press_code", kif.key_code, 6);
    bad = 0;
    repeat (40) begin tick(1); if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd6) bad++; end
    check("press_hold", bad, 0);
    accept();
    check("accept_clear", kif.key_valid, 0);
    bad = 0;
    repeat (100) begin tick(1); if (kif.key_valid !== 1'b0) bad++; end
    check("no_repeat", bad, 0);

    // bounce on key 6
    keys = 16'h0;
    tick(5 * FR);
    wait_frame_start();
    tick(4);
    bad = 0;
    for (int t = 0; t < 6; t++) begin
      keys = (t % 2 == 0) ? 16'h0040 : 16'h0000;
      repeat (10) begin tick(1); if (kif.key_valid !== 1'b0) bad++; end
    end
    check("bounce_quiet", bad, 0);
    keys = 16'h0040;
    wait_valid(120, lat);
    check("bounce_event", kif.key_valid, 1);
    check("bounce_code", kif.key_code, 6);
    accept();
    bad = 0;
    repeat (100) begin tick(1); if (kif.key_valid !== 1'b0) bad++; end
    check("bounce_single", bad, 0);

    // ghosting: {0,5} then {0} then release, then key 15
    bad = 0;
    keys = 16'h0021;
    repeat (6 * FR) begin tick(1); if (kif.key_valid !== 1'b0) bad++; end
    keys = 16'h0001;
    repeat (6 * FR) begin tick(1); if (kif.key_valid !== 1'b0) bad++; end
    check("ghost_quiet", bad, 0);
    keys = 16'h0;
    tick(5 * FR);
    wait_frame_start();
    keys = 16'h8000;
    wait_valid(80, lat);
    check("key15_valid", kif.key_valid, 1);
    check("key15_code", kif.key_code, 15);
    accept();

    // overflow: key 3 pending, then key 9
    keys = 16'h0;
    tick(5 * FR);
    wait_frame_start();
    keys = 16'h0008;
    wait_valid(80, lat);
    check("key3_code", kif.key_code, 3);
    keys = 16'h0;
    tick(5 * FR);
    wait_frame_start();
    keys = 16'h0200;
    ovf_cnt = 0;
    repeat (80) begin tick(1); if (kif.key_overflow === 1'b1) ovf_cnt++; end
    check("ovf_pulse", ovf_cnt, 1);
    check("ovf_code_kept", kif.key_code, 3);
    check("ovf_valid_kept", kif.key_valid, 1);

    // simultaneous transfer and event: ready high only on the event cycle (cycle 49 of the press frame)
    keys = 16'h0;
    tick(5 * FR);
    wait_frame_start();
    keys = 16'h0200;
    bad = 0;
    ovf_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      kif.key_ready = (k == 50);
      tick(1);
      if (kif.key_valid !== 1'b1) bad++;
      if (kif.key_overflow === 1'b1) ovf_cnt++;
    end
    kif.key_ready = 1'b0;
    check("simul_valid_held", bad, 0);
    check("simul_no_ovf", ovf_cnt, 0);
    check("simul_code", kif.key_code, 9);

    // asynchronous reset mid column 2
    n = 0;
    while (cols_oeb !== 4'hB && n < 50) begin tick(1); n++; end
    check("pre_reset_valid", kif.key_valid, 1);
    nrst = 1'b0;
    #1;
    check("mid_rst_cols_out", cols_out, 4'hF);
    check("mid_rst_cols_oeb", cols_oeb, 4'hF);
    check("mid_rst_valid", kif.key_valid, 0);
    check("mid_rst_code", kif.key_code, 0);
    check("mid_rst_ovf", kif.key_overflow, 0);
    keys = 16'h0;
    tick(2);
    nrst = 1'b1;

    // en drop mid-frame
    wait_frame_start();
    keys = 16'h0020;
    wait_valid(80, lat);
    check("key5_code", kif.key_code, 5);
    n = 0;
    while (cols_oeb !== 4'hD && n < 50) begin tick(1); n++; end
    en = 1'b0;
    tick(1);
    check("en_drop_valid", kif.key_valid, 0);
    check("en_drop_oeb", cols_oeb, 4'hF);
    check("en_drop_out", cols_out, 4'hF);
    en = 1'b1;
    tick(1);
    check("en_restart_col0", cols_oeb, 4'hE);
    tick(4);
    check("en_restart_col1", cols_oeb, 4'hD);

    // randomized key sequences against a frame-level reference model
    nrst = 1'b0;
    en = 1'b0;
    keys = 16'h0;
    tick(2);
    nrst = 1'b1;
    en = 1'b1;
    wait_frame_start();
    r_ovf = 0;
    frames.push_back(16'h0);
    frames.push_back(16'h0);
    m = 16'h0;
    for (int r = 0; r < 30; r++) begin
      int sel, dur;
      sel = $urandom % 4;
      dur = 1 + $urandom % 4;
      case (sel)
        0: m = 16'h0;
        1: m = 16'h1 << ($urandom % 16);
        2: m = (16'h1 << ($urandom % 16)) | (16'h1 << ($urandom % 16));
        default: m = m;
      endcase
      keys = m;
      repeat (dur) frames.push_back(m);
      repeat (dur * FR) step();
    end
    keys = 16'h0;
    repeat (6) frames.push_back(16'h0);
    repeat (6 * FR + 8) step();
    kif.key_ready = 1'b0;

    // debounced state takes a value once it has been seen DB+1 frames in a row
    deb = 16'h0;
    for (int i = 1; i < frames.size(); i++) begin
      int run, j;
      run = 1;
      j = i - 1;
      while (j >= 0 && frames[j] == frames[i]) begin run++; j--; end
      if (run == DB + 1) begin
        if ($countones(frames[i]) == 1 && (frames[i] & deb) == 16'h0) begin
          for (int b = 0; b < 16; b++) if (frames[i][b]) expq.push_back(4'(b));
        end
        deb = frames[i];
      end
    end
    check("rand_event_count", got.size(), expq.size());
    for (int k = 0; k < got.size() && k < expq.size(); k++) check("rand_code", got[k], expq[k]);
    check("rand_no_ovf", r_ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
